seg_bcd_arbiter: RTL

Shares one sequential binary-to-BCD engine between two 16-bit requesters, e.g. the two player score counters feeding the seven-segment display path. A round-robin arbiter grants one requester at a time. An iterative shift-and-add-3 datapath converts the operand over 16 cycles. Each requester gets its own held 5-digit BCD result register and a completion pulse.

---
 rtl/seg_bcd_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/seg_bcd_arbiter.sv
// seg_bcd_arbiter
// ---------------------------------------------------------------------------
// Purpose: shares one iterative shift-and-add-3 binary-to-BCD engine between
// two requesters. A round-robin arbiter picks one pending request, the
// operand is converted over W cycles, and the result lands in that
// requester's own held BCD register with a one-cycle completion pulse.
//
// Handshake: req* is a level that the requester holds until it sees ack*.
// ack* is a one-cycle registered pulse on the cycle after the grant edge and
// means bin* has been captured. Later changes to bin* do not affect the
// conversion. done* is a one-cycle registered pulse meaning bcd* has just
// been written. A req* still high after done* counts as a new request.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req0/bin0            requester 0 request level / operand
//   ack0/done0/bcd0      requester 0 accept pulse / done pulse / held result
//   req1/bin1            requester 1 request level / operand
//   ack1/done1/bcd1      requester 1 accept pulse / done pulse / held result
//   busy                 high whenever the FSM is not in IDLE
//   state_o              current FSM state (0 IDLE, 1 SHIFT, 2 DONE), debug
// ---------------------------------------------------------------------------
module seg_bcd_arbiter #(
  parameter int W    = 16,
  parameter int NDIG = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [W-1:0]      bin0,
  output logic              ack0,
  output logic              done0,
  output logic [4*NDIG-1:0] bcd0,
  input  logic              req1,
  input  logic [W-1:0]      bin1,
  output logic              ack1,
  output logic              done1,
  output logic [4*NDIG-1:0] bcd1,
  output logic              busy,
  output logic [1:0]        state_o
);

  localparam int BW = 4 * NDIG;   // BCD field width
  localparam int ZW = BW + W;     // shift register: {bcd, binary}
  localparam int CW = $clog2(W);  // iteration counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ZW-1:0]   z_q, z_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pri_q, pri_d;
  logic            own_q, own_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            done0_q, done0_d;
  logic            done1_q, done1_d;
  logic [BW-1:0]   bcd0_q, bcd0_d;
  logic [BW-1:0]   bcd1_q, bcd1_d;

  // Arbitration: a lone requester wins outright; on a tie pri picks.
  logic            gnt_any;
  logic            gnt_sel;
  // z after the add-3 correction of every BCD nibble, before the shift.
  logic [ZW-1:0]   z_adj;

  always_comb begin
    gnt_any = req0 | req1;
    gnt_sel = (req0 & req1) ? pri_q : req1;

    z_adj = z_q;
    for (int k = 0; k < NDIG; k++) begin
      // A nibble above 4 would reach 10+ after the shift; pre-adding 3
      // makes the shift carry into the next digit. Cannot overflow 4 bits.
      if (z_q[W+4*k +: 4] > 4'd4) begin
        z_adj[W+4*k +: 4] = z_q[W+4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    pri_d   = pri_q;
    own_d   = own_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    bcd0_d  = bcd0_q;
    bcd1_d  = bcd1_q;

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          z_d     = {{BW{1'b0}}, (gnt_sel ? bin1 : bin0)};
          cnt_d   = '0;
          own_d   = gnt_sel;
          pri_d   = ~gnt_sel;
          ack0_d  = ~gnt_sel;
          ack1_d  = gnt_sel;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        z_d   = {z_adj[ZW-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (own_q) begin
          bcd1_d  = z_q[ZW-1:W];
          done1_d = 1'b1;
        end else begin
          bcd0_d  = z_q[ZW-1:W];
          done0_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      z_q     <= '0;
      cnt_q   <= '0;
      pri_q   <= 1'b0;
      own_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      bcd0_q  <= '0;
      bcd1_q  <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      pri_q   <= pri_d;
      own_q   <= own_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      bcd0_q  <= bcd0_d;
      bcd1_q  <= bcd1_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign bcd0    = bcd0_q;
  assign bcd1    = bcd1_q;
  assign busy    = (state_q != IDLE);
  assign state_o = state_q;

endmodule
